// File: rtl/sd_defs.sv
// Shared SD host definitions: response lengths, CRC7 polynomial, receiver state codes
// and a serial CRC7 step helper shared by the command sender and the response receiver.
package sd_defs;

  localparam int RESP_LEN_SHORT = 48;
  localparam int RESP_LEN_LONG  = 136;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_START = 3'd1;
  localparam logic [2:0] ST_RECV       = 3'd2;
  localparam logic [2:0] ST_CHECK      = 3'd3;
  localparam logic [2:0] ST_DONE       = 3'd4;

  typedef enum logic [1:0] {
    RESP_R1 = 2'd0,
    RESP_R2 = 2'd1,
    RESP_R3 = 2'd2,
    RESP_R6 = 2'd3
  } resp_type_e;

  // x^7 + x^3 + 1, one message bit per call, MSB first
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    crc7_step = {crc[5:0], 1'b0} ^ ((crc[6] ^ b) ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 generator; clear has priority over enable.
module sd_crc7
  import sd_defs::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= crc7_step(crc_q, bit_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_resp_rx.sv
// SD CMD-line response receiver: waits for the start bit, deserialises a 48- or 136-bit
// response on sample strobes, checks framing and CRC7, and reports with a one-cycle done.
module sd_cmd_resp_rx
  import sd_defs::*;
#(
  parameter int NCR_MAX = 64,
  parameter int NCR_W   = 7
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         sample_en_i,
  input  logic         cmd_pin_i,
  input  logic         arm_i,
  input  logic         long_resp_i,
  input  logic         crc_chk_i,
  input  logic         abort_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [5:0]   resp_index_o,
  output logic [31:0]  resp_arg_o,
  output logic [119:0] resp_cid_o,
  output logic         crc_err_o,
  output logic         frame_err_o,
  output logic         timeout_o
);

  localparam logic [7:0]       LEN_S    = 8'(RESP_LEN_SHORT);
  localparam logic [7:0]       LEN_L    = 8'(RESP_LEN_LONG);
  localparam logic [NCR_W-1:0] NCR_LAST = NCR_W'(NCR_MAX - 1);

  logic [2:0]       state_q, state_d;
  logic             long_q, long_d;
  logic             chk_q, chk_d;
  logic [NCR_W-1:0] ncr_q, ncr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [135:0]     shift_q, shift_d;
  logic [5:0]       index_q, index_d;
  logic [31:0]      arg_q, arg_d;
  logic [119:0]     cid_q, cid_d;
  logic             crc_err_q, crc_err_d;
  logic             frame_err_q, frame_err_d;
  logic             timeout_q, timeout_d;

  logic       crc_clr, crc_en, take_bit;
  logic [6:0] crc_val;
  logic [7:0] bit_num, frame_len;

  sd_crc7 u_crc7 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (crc_clr),
    .en_i    (crc_en),
    .bit_i   (cmd_pin_i),
    .crc_o   (crc_val)
  );

  assign frame_len = long_q ? LEN_L : LEN_S;
  assign bit_num   = 8'(cnt_q + 8'd1);

  always_comb begin
    state_d     = state_q;
    long_d      = long_q;
    chk_d       = chk_q;
    ncr_d       = ncr_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    index_d     = index_q;
    arg_d       = arg_q;
    cid_d       = cid_q;
    crc_err_d   = crc_err_q;
    frame_err_d = frame_err_q;
    timeout_d   = timeout_q;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;
    take_bit    = 1'b0;

    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_i) begin
            state_d     = ST_WAIT_START;
            long_d      = long_resp_i;
            chk_d       = crc_chk_i;
            ncr_d       = '0;
            cnt_d       = '0;
            shift_d     = '0;
            crc_err_d   = 1'b0;
            frame_err_d = 1'b0;
            timeout_d   = 1'b0;
            crc_clr     = 1'b1;
          end
        end
        ST_WAIT_START: begin
          if (sample_en_i) begin
            if (!cmd_pin_i) begin
              state_d  = ST_RECV;
              cnt_d    = 8'd1;
              shift_d  = {shift_q[134:0], cmd_pin_i};
              take_bit = 1'b1;
            end else begin
              ncr_d = NCR_W'(ncr_q + 1'b1);
              if (ncr_q == NCR_LAST) begin
                state_d   = ST_DONE;
                timeout_d = 1'b1;
              end
            end
          end
        end
        ST_RECV: begin
          if (sample_en_i) begin
            shift_d  = {shift_q[134:0], cmd_pin_i};
            cnt_d    = bit_num;
            take_bit = 1'b1;
            if (bit_num == frame_len) state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          // start bit is folded into frame_err alongside the transmission and end bits
          if (long_q) begin
            index_d     = shift_q[133:128];
            cid_d       = shift_q[127:8];
            frame_err_d = shift_q[135] | shift_q[134] | ~shift_q[0];
          end else begin
            index_d     = shift_q[45:40];
            arg_d       = shift_q[39:8];
            frame_err_d = shift_q[47] | shift_q[46] | ~shift_q[0];
          end
          crc_err_d = chk_q && (crc_val != shift_q[7:1]);
          state_d   = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    // R2 CRC skips the 8-bit header; no frame feeds its CRC field or end bit
    if (take_bit) begin
      if (long_q && bit_num <= 8'd8) begin
        crc_clr = 1'b1;
      end else if (bit_num <= 8'(frame_len - 8'd8)) begin
        crc_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      long_q      <= 1'b0;
      chk_q       <= 1'b0;
      ncr_q       <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      index_q     <= '0;
      arg_q       <= '0;
      cid_q       <= '0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      long_q      <= long_d;
      chk_q       <= chk_d;
      ncr_q       <= ncr_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      index_q     <= index_d;
      arg_q       <= arg_d;
      cid_q       <= cid_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy_o       = (state_q == ST_WAIT_START) || (state_q == ST_RECV) || (state_q == ST_CHECK);
  assign done_o       = (state_q == ST_DONE);
  assign resp_index_o = index_q;
  assign resp_arg_o   = arg_q;
  assign resp_cid_o   = cid_q;
  assign crc_err_o    = crc_err_q;
  assign frame_err_o  = frame_err_q;
  assign timeout_o    = timeout_q;

endmodule
